serial_word_tx: RTL and testbench
=================================

// Module: serial_word_tx
// PURPOSE
// - Parallel-in, serial-out transmitter: accepts an NBITS word on a start/ready handshake and shifts it out LSB first.
// - Each bit is presented on serial_out with a one-cycle shift_en strobe per bit.
// - Drives the serial-in/parallel-out shift register on the FPGA board (serial -> data, shift_en -> shift select).
// - After NBITS strobes, the word reappears intact in the receiver's parallel output.
// - Sits between SWI/LED/SEG board I/O and the receiver; purely clk_2 domain.
// PARAMETERS
// - NBITS       4  word width, legal range 2..16
// - BIT_CYCLES  1  clk_2 cycles each bit is held on serial_out, legal range >=1
// PORTS
// - clk_2      in   1      system clock (divided board clock)
// - reset      in   1      reset, synchronous, active-high; clock clk_2
// - start      in   1      request to send data_in; accepted only when ready=1
// - data_in    in   NBITS  word to send; sampled on the accepting edge only
// - ready      out  1      1 = idle, start will be accepted this cycle
// - busy       out  1      1 = frame in progress (SHIFT or DONE)
// - serial_out out  1      current bit, LSB first; 0 when not in SHIFT
// - shift_en   out  1      1-cycle strobe: receiver samples serial_out at this edge
// - done       out  1      1-cycle pulse, asserted in the cycle after the last strobe
// - bit_cnt    out  $clog2(NBITS+1)  bits already strobed in the current frame
// BEHAVIOUR
// - All outputs are decoded from registered state (state, shreg, cnt, timer); no input->output combinational path.
// - Reset values (state IDLE): ready=1, busy=0, serial_out=0, shift_en=0, done=0, bit_cnt=0, shreg=0, timer=0.
// - FSM IDLE:
//   - start=1 -> shreg<=data_in, timer<=0, bit_cnt<=0, go to SHIFT.
//   - start=0 -> stay in IDLE.
// - FSM SHIFT:
//   - serial_out=shreg[0].
//   - tick = (timer==BIT_CYCLES-1); shift_en=tick.
//   - timer increments each cycle and wraps to 0 on tick.
//   - On tick: shreg<=shreg>>1 (zero-fill MSB), bit_cnt++.
//   - Tick with bit_cnt==NBITS-1 -> go to DONE.
// - FSM DONE: done=1, busy=1, ready=0; unconditionally IDLE next cycle.
// - Latency: start accepted at edge N.
//   - Bit k is on serial_out during cycles N+1+k*BIT_CYCLES .. N+(k+1)*BIT_CYCLES.
//   - done is asserted in cycle N+NBITS*BIT_CYCLES+1; ready returns one cycle later.
// - start while ready=0 (SHIFT or DONE) is ignored and not queued. data_in changes after acceptance have no effect.
// - start held high continuously: back-to-back frames, one idle (ready) cycle between done and the next frame.
// - Reset asserted mid-frame: frame aborted at that edge, no done pulse, all outputs at reset values next cycle.
// - reset and start in the same cycle: reset wins, start discarded.
// - BIT_CYCLES=1: shift_en is high every SHIFT cycle; timer is held at 0.
// - bit_cnt saturates at NBITS in DONE and clears on the next acceptance.
// STRUCTURE
// - Package serial_tx_pkg:
//   - typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_DONE} tx_state_t.
//   - Default constants TX_NBITS=4, TX_BIT_CYCLES=1.
// - Sub-module bit_timer #(BIT_CYCLES):
//   - Ports clk_2, reset, run, tick.
//   - Counter cleared when run=0; tick on terminal count.
// - Top-level board wrapper maps SWI[7:4]->data_in, SWI[0]->start, SWI[1]->reset, LED[0]->serial_out, LED[1]->busy.
// TESTING
// - T1 reset: reset=1 for 2 cycles with start=1 -> ready=1, busy=0, serial_out=0, shift_en=0, done=0 after release.
// - T2 basic frame (NBITS=4, BIT_CYCLES=1):
//   - Stimulus: start=1, data_in=4'b1011 at edge N.
//   - serial_out = 1,1,0,1 in cycles N+1..N+4, shift_en=1 in those cycles.
//   - done=1 at N+5; ready=1 at N+6.
// - T3 loopback: feed serial_out/shift_en into a 4-bit SIPO model (serial enters MSB, shifts right).
//   - After the frame of 4'hB, the model holds 4'hB.
//   - Repeat with 4'h0, 4'hF, 4'h6.
// - T4 BIT_CYCLES=3, data 4'b0110:
//   - Each bit is held 3 cycles.
//   - shift_en only on the 3rd cycle of each bit (cycles N+3, N+6, N+9, N+12).
//   - done at N+13.
// - T5 busy rejection: start pulse with data 4'h9 at N+2 of a 4'h5 frame -> 4'h5 sent unchanged, no second frame, bit_cnt unaffected.
// - T6 abort: reset at cycle N+2 of a frame -> no done pulse, outputs at reset values.
//   - A following start with 4'hA sends the complete 4'hA frame.

Source files
------------

// File: rtl/serial_word_tx_pkg.sv
// Shared types and default parameters for the serial word transmitter.
package serial_tx_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_DONE} tx_state_t;

  localparam int unsigned TX_NBITS      = 4;
  localparam int unsigned TX_BIT_CYCLES = 1;

endpackage

// File: rtl/serial_word_tx_if.sv
// Handshake and serial-side signals between a word source and the transmitter.
interface serial_word_tx_if
  import serial_tx_pkg::*;
#(
  parameter int unsigned NBITS = TX_NBITS
);
  logic                         start;
  logic [NBITS-1:0]             data_in;
  logic                         ready;
  logic                         busy;
  logic                         serial_out;
  logic                         shift_en;
  logic                         done;
  logic [$clog2(NBITS+1)-1:0]   bit_cnt;

  modport master (
    output start, data_in,
    input  ready, busy, serial_out, shift_en, done, bit_cnt
  );

  modport slave (
    input  start, data_in,
    output ready, busy, serial_out, shift_en, done, bit_cnt
  );
endinterface

// File: rtl/serial_word_tx_bit_timer.sv
// Per-bit hold timer: counts clk_2 cycles while run=1 and ticks on the terminal count.
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = TX_BIT_CYCLES
) (
  input  logic clk_2,
  input  logic reset,
  input  logic run,
  output logic tick
);
  localparam int unsigned   TW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] TERM = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          w_term;

  assign w_term = (r_timer == TERM);
  assign tick   = run && w_term;

  // With BIT_CYCLES=1 the terminal count is 0, so the timer never leaves 0.
  always_ff @(posedge clk_2) begin
    if (reset || !run) begin
      r_timer <= '0;
    end else if (w_term) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end
endmodule

// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter: LSB first, one shift_en strobe per bit.
module serial_word_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned NBITS      = TX_NBITS,
  parameter int unsigned BIT_CYCLES = TX_BIT_CYCLES
) (
  input  logic             clk_2,
  input  logic             reset,
  serial_word_tx_if.slave  tx
);
  localparam int unsigned CW = $clog2(NBITS + 1);

  tx_state_t        r_state;
  tx_state_t        w_next;
  logic [NBITS-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             w_run;
  logic             w_tick;
  logic             w_accept;
  logic             w_last;

  assign w_run    = (r_state == TX_SHIFT);
  assign w_accept = (r_state == TX_IDLE) && tx.start;
  assign w_last   = (r_cnt == CW'(NBITS - 1));

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk_2 (clk_2),
    .reset (reset),
    .run   (w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    tx.ready      = 1'b0;
    tx.busy       = 1'b0;
    tx.serial_out = 1'b0;
    tx.shift_en   = 1'b0;
    tx.done       = 1'b0;
    tx.bit_cnt    = r_cnt;
    case (r_state)
      TX_IDLE: begin
        tx.ready = 1'b1;
        if (tx.start) begin
          w_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        tx.busy       = 1'b1;
        tx.serial_out = r_shreg[0];
        tx.shift_en   = w_tick;
        if (w_tick && w_last) begin
          w_next = TX_DONE;
        end
      end
      TX_DONE: begin
        tx.busy = 1'b1;
        tx.done = 1'b1;
        w_next  = TX_IDLE;
      end
      default: begin
        w_next = TX_IDLE;
      end
    endcase
  end

  // The count is left at NBITS through DONE/IDLE and only cleared on the next acceptance.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shreg <= tx.data_in;
      r_cnt   <= '0;
    end else if (w_run && w_tick) begin
      r_shreg <= r_shreg >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: SIPO receiver model plus a word scoreboard.
module tb_serial_word_tx;
  import serial_tx_pkg::*;

  logic clk_2 = 1'b0;
  logic reset;

  always #5 clk_2 = ~clk_2;

  serial_word_tx_if #(.NBITS(4)) b1 ();
  serial_word_tx_if #(.NBITS(4)) b3 ();

  serial_word_tx #(.NBITS(4), .BIT_CYCLES(1)) dut1 (
    .clk_2 (clk_2),
    .reset (reset),
    .tx    (b1.slave)
  );

  serial_word_tx #(.NBITS(4), .BIT_CYCLES(3)) dut3 (
    .clk_2 (clk_2),
    .reset (reset),
    .tx    (b3.slave)
  );

  int checks    = 0;
  int failures  = 0;
  int done_cnt1 = 0;
  int base;

  logic [3:0] q1[$];
  logic [3:0] q3[$];
  logic [3:0] sipo1;
  logic [3:0] sipo3;
  logic [3:0] w;
  logic [3:0] pat[4];

  // Receiver model: serial enters at the MSB and the register shifts right on each strobe.
  always @(posedge clk_2) begin
    if (b1.shift_en === 1'b1) sipo1 <= {b1.serial_out, sipo1[3:1]};
    if (b3.shift_en === 1'b1) sipo3 <= {b3.serial_out, sipo3[3:1]};
    if (b1.done === 1'b1) done_cnt1 <= done_cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic wait_done1(input string tag);
    int n = 0;
    while (b1.done !== 1'b1 && n < 40) begin
      @(negedge clk_2);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(b1.done), 32'd1);
  endtask

  task automatic pop1(input string tag);
    logic [3:0] e;
    if (q1.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q1.pop_front();
      chk({tag, "_word"}, 32'(sipo1), 32'(e));
    end
  endtask

  task automatic send1(input logic [3:0] word, input string tag);
    b1.data_in = word;
    b1.start   = 1'b1;
    q1.push_back(word);
    @(negedge clk_2);
    b1.start   = 1'b0;
    b1.data_in = '0;
    wait_done1(tag);
    pop1(tag);
    @(negedge clk_2);
    chk({tag, "_ready"}, 32'(b1.ready), 32'd1);
  endtask

  initial begin
    // T1: reset wins over start.
    reset      = 1'b1;
    b1.start   = 1'b1;
    b1.data_in = 4'hF;
    b3.start   = 1'b1;
    b3.data_in = 4'hF;
    cyc(2);
    chk("t1_ready", 32'(b1.ready), 32'd1);
    chk("t1_busy", 32'(b1.busy), 32'd0);
    chk("t1_serial", 32'(b1.serial_out), 32'd0);
    chk("t1_shift_en", 32'(b1.shift_en), 32'd0);
    chk("t1_done", 32'(b1.done), 32'd0);
    chk("t1_bit_cnt", 32'(b1.bit_cnt), 32'd0);
    chk("t1_ready3", 32'(b3.ready), 32'd1);
    reset    = 1'b0;
    b1.start = 1'b0;
    b3.start = 1'b0;
    cyc(1);
    chk("t1_post_ready", 32'(b1.ready), 32'd1);
    chk("t1_post_busy", 32'(b1.busy), 32'd0);

    // T2: basic frame, cycle-exact.
    w          = 4'b1011;
    b1.data_in = w;
    b1.start   = 1'b1;
    q1.push_back(w);
    @(negedge clk_2);
    b1.start   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_serial%0d", k), 32'(b1.serial_out), 32'(w[k]));
      chk($sformatf("t2_shift_en%0d", k), 32'(b1.shift_en), 32'd1);
      chk($sformatf("t2_bit_cnt%0d", k), 32'(b1.bit_cnt), 32'(k));
      chk($sformatf("t2_busy%0d", k), 32'(b1.busy), 32'd1);
      @(negedge clk_2);
    end
    chk("t2_done", 32'(b1.done), 32'd1);
    chk("t2_done_ready", 32'(b1.ready), 32'd0);
    chk("t2_done_busy", 32'(b1.busy), 32'd1);
    chk("t2_done_bit_cnt", 32'(b1.bit_cnt), 32'd4);
    chk("t2_done_serial", 32'(b1.serial_out), 32'd0);
    pop1("t2");
    @(negedge clk_2);
    chk("t2_done_pulse", 32'(b1.done), 32'd0);
    chk("t2_ready_back", 32'(b1.ready), 32'd1);

    // T3: loopback through the receiver model.
    pat = '{4'hB, 4'h0, 4'hF, 4'h6};
    for (int i = 0; i < 4; i++) begin
      send1(pat[i], $sformatf("t3_%0h", pat[i]));
    end

    // T4: BIT_CYCLES=3, each bit held for three cycles.
    w          = 4'b0110;
    b3.data_in = w;
    b3.start   = 1'b1;
    q3.push_back(w);
    @(negedge clk_2);
    b3.start   = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("t4_shift_en_c%0d", c), 32'(b3.shift_en), 32'((c % 3 == 0) && (c <= 12)));
      chk($sformatf("t4_serial_c%0d", c), 32'(b3.serial_out), (c <= 12) ? 32'(w[(c-1)/3]) : 32'd0);
      chk($sformatf("t4_done_c%0d", c), 32'(b3.done), 32'(c == 13));
      if (c < 13) @(negedge clk_2);
    end
    if (q3.size() == 0) chk("t4_sb_empty", 32'd0, 32'd1);
    else chk("t4_word", 32'(sipo3), 32'(q3.pop_front()));
    @(negedge clk_2);
    chk("t4_ready", 32'(b3.ready), 32'd1);

    // T5: start while busy is ignored.
    base       = done_cnt1;
    b1.data_in = 4'h5;
    b1.start   = 1'b1;
    q1.push_back(4'h5);
    @(negedge clk_2);
    b1.start   = 1'b0;
    chk("t5_bit0", 32'(b1.serial_out), 32'd1);
    @(negedge clk_2);
    b1.start   = 1'b1;
    b1.data_in = 4'h9;
    @(negedge clk_2);
    b1.start   = 1'b0;
    b1.data_in = '0;
    chk("t5_bit_cnt", 32'(b1.bit_cnt), 32'd2);
    chk("t5_bit2", 32'(b1.serial_out), 32'd1);
    wait_done1("t5");
    pop1("t5");
    cyc(8);
    chk("t5_one_frame", 32'(done_cnt1 - base), 32'd1);
    chk("t5_idle", 32'(b1.ready), 32'd1);

    // T6: reset mid-frame aborts without a done pulse.
    base       = done_cnt1;
    b1.data_in = 4'h3;
    b1.start   = 1'b1;
    @(negedge clk_2);
    b1.start   = 1'b0;
    @(negedge clk_2);
    reset      = 1'b1;
    @(negedge clk_2);
    chk("t6_ready", 32'(b1.ready), 32'd1);
    chk("t6_busy", 32'(b1.busy), 32'd0);
    chk("t6_serial", 32'(b1.serial_out), 32'd0);
    chk("t6_shift_en", 32'(b1.shift_en), 32'd0);
    chk("t6_done", 32'(b1.done), 32'd0);
    chk("t6_bit_cnt", 32'(b1.bit_cnt), 32'd0);
    reset = 1'b0;
    cyc(6);
    chk("t6_no_done", 32'(done_cnt1 - base), 32'd0);
    send1(4'hA, "t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
